// File: rtl/vga_text_render.sv
// ---------------------------------------------------------------------------
// Module      : vga_text_render
// Description : Three-stage monochrome text-mode pixel pipeline. Stage 1
//               addresses the text RAM, stage 2 addresses the font ROM,
//               stage 3 picks the glyph bit, applies a blinking cursor and
//               delays the syncs to stay aligned with the pixel.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module vga_text_render #(
  parameter int COLUMNS     = 80,
  parameter int ROWS        = 30,
  parameter int CELL_WIDTH  = 10,
  parameter int CELL_HEIGHT = 16
) (
  input  logic        clk,
  input  logic        reset_low,
  input  logic        pixel_tick,
  input  logic        h_active,
  input  logic        h_sync,
  input  logic [6:0]  h_block,
  input  logic [3:0]  h_pixel,
  input  logic        v_active,
  input  logic        v_sync,
  input  logic [4:0]  v_block,
  input  logic [3:0]  v_pixel,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_enable,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_active,
  output logic        vga_pixel
);

  // Bounds widened by one bit so a full-range parameter still compares correctly.
  localparam logic [7:0] c_COLS   = 8'(COLUMNS);
  localparam logic [5:0] c_ROWS   = 6'(ROWS);
  localparam logic [7:0] c_CELL_W = 8'(CELL_WIDTH);
  localparam logic [7:0] c_CELL_H = 8'(CELL_HEIGHT);

  // Stage 1 registers
  logic [11:0] text_addr_q;
  logic [3:0]  s1_hpix_q, s1_vpix_q;
  logic        s1_active_q, s1_hsync_q, s1_vsync_q, s1_cursor_q;
  // Stage 2 registers
  logic [11:0] font_addr_q;
  logic [3:0]  s2_hpix_q;
  logic        s2_active_q, s2_hsync_q, s2_vsync_q, s2_cursor_q, s2_rowok_q;
  // Stage 3 (output) registers and frame counter
  logic        vga_hsync_q, vga_vsync_q, vga_active_q, vga_pixel_q;
  logic [4:0]  blink_cnt_q;

  // Next-state values
  logic [11:0] text_addr_d;
  logic        cursor_hit_d, rowok_d, glyph_d, pixel_d, vfall_d;

  // Address arithmetic, cursor match and pixel selection
  always_comb begin
    text_addr_d  = 12'(v_block) * 12'(COLUMNS) + 12'(h_block);
    // A cursor parked outside the text area can never match a real cell.
    cursor_hit_d = (h_block == cursor_col) && (v_block == cursor_row) &&
                   ({1'b0, cursor_col} < c_COLS) && ({1'b0, cursor_row} < c_ROWS);
    rowok_d      = ({4'b0, s1_vpix_q} < c_CELL_H);
    glyph_d      = 1'b0;
    // Pixels 8 and up of a cell are the inter-character gap.
    if (!s2_hpix_q[3] && ({4'b0, s2_hpix_q} < c_CELL_W) && s2_rowok_q) begin
      glyph_d = font_data[~s2_hpix_q[2:0]];
    end
    pixel_d      = s2_active_q & (glyph_d ^ (s2_cursor_q & cursor_enable & blink_cnt_q[4]));
    vfall_d      = vga_vsync_q & ~s2_vsync_q;
  end

  // Stage 1: text RAM address and axis sampling
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      text_addr_q <= '0;
      s1_hpix_q   <= '0;
      s1_vpix_q   <= '0;
      s1_active_q <= 1'b0;
      s1_hsync_q  <= 1'b1;
      s1_vsync_q  <= 1'b1;
      s1_cursor_q <= 1'b0;
    end else if (pixel_tick) begin
      text_addr_q <= text_addr_d;
      s1_hpix_q   <= h_pixel;
      s1_vpix_q   <= v_pixel;
      s1_active_q <= h_active & v_active;
      s1_hsync_q  <= h_sync;
      s1_vsync_q  <= v_sync;
      s1_cursor_q <= cursor_hit_d;
    end
  end

  // Stage 2: font ROM address from the fetched character code
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      font_addr_q <= '0;
      s2_hpix_q   <= '0;
      s2_active_q <= 1'b0;
      s2_hsync_q  <= 1'b1;
      s2_vsync_q  <= 1'b1;
      s2_cursor_q <= 1'b0;
      s2_rowok_q  <= 1'b0;
    end else if (pixel_tick) begin
      font_addr_q <= {text_data, s1_vpix_q};
      s2_hpix_q   <= s1_hpix_q;
      s2_active_q <= s1_active_q;
      s2_hsync_q  <= s1_hsync_q;
      s2_vsync_q  <= s1_vsync_q;
      s2_cursor_q <= s1_cursor_q;
      s2_rowok_q  <= rowok_d;
    end
  end

  // Stage 3: rendered pixel, delayed syncs and frame-based blink counter
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      vga_hsync_q  <= 1'b1;
      vga_vsync_q  <= 1'b1;
      vga_active_q <= 1'b0;
      vga_pixel_q  <= 1'b0;
      blink_cnt_q  <= '0;
    end else if (pixel_tick) begin
      vga_hsync_q  <= s2_hsync_q;
      vga_vsync_q  <= s2_vsync_q;
      vga_active_q <= s2_active_q;
      vga_pixel_q  <= pixel_d;
      if (vfall_d) begin
        blink_cnt_q <= blink_cnt_q + 5'd1;
      end
    end
  end

  assign text_addr  = text_addr_q;
  assign font_addr  = font_addr_q;
  assign vga_hsync  = vga_hsync_q;
  assign vga_vsync  = vga_vsync_q;
  assign vga_active = vga_active_q;
  assign vga_pixel  = vga_pixel_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_render.sv
// ---------------------------------------------------------------------------
// Module      : tb_vga_text_render
// Description : Bench for vga_text_render with behavioural text RAM / font
//               ROM and a scoreboard model of the rendered output stream.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        reset_low;
  logic        pixel_tick;
  logic        h_active, h_sync, v_active, v_sync;
  logic [6:0]  h_block;
  logic [3:0]  h_pixel;
  logic [4:0]  v_block;
  logic [3:0]  v_pixel;
  logic [11:0] text_addr, font_addr;
  logic [7:0]  text_data, font_data;
  logic        cursor_enable;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        vga_hsync, vga_vsync, vga_active, vga_pixel;

  vga_text_render dut (
    .clk           (clk),
    .reset_low     (reset_low),
    .pixel_tick    (pixel_tick),
    .h_active      (h_active),
    .h_sync        (h_sync),
    .h_block       (h_block),
    .h_pixel       (h_pixel),
    .v_active      (v_active),
    .v_sync        (v_sync),
    .v_block       (v_block),
    .v_pixel       (v_pixel),
    .text_addr     (text_addr),
    .text_data     (text_data),
    .font_addr     (font_addr),
    .font_data     (font_data),
    .cursor_enable (cursor_enable),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_active    (vga_active),
    .vga_pixel     (vga_pixel)
  );

  always #5 clk = ~clk;

  // Memories answer within the clock after the address changes.
  logic [7:0] text_mem [0:4095];
  logic [7:0] font_mem [0:4095];
  assign text_data = text_mem[text_addr];
  assign font_data = font_mem[font_addr];

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic glyph;
    logic hit;
  } exp_t;

  typedef struct packed {
    logic [6:0]  hb;
    logic [3:0]  hp;
    logic [4:0]  vb;
    logic [3:0]  vp;
    logic        ha;
    logic        va;
    logic        hs;
    logic        vs;
    logic [11:0] exp_taddr;
  } vec_t;

  exp_t       sbq [$];
  vec_t       tbl [10];
  int         total = 0;
  int         bad   = 0;
  logic [4:0] m_cnt;
  logic       m_prev_vs;

  function automatic vec_t mk(input logic [6:0] hb, input logic [3:0] hp,
                              input logic [4:0] vb, input logic [3:0] vp,
                              input logic ha, input logic va, input logic hs,
                              input logic vs, input logic [11:0] ta);
    vec_t v;
    v.hb = hb; v.hp = hp; v.vb = vb; v.vp = vp;
    v.ha = ha; v.va = va; v.hs = hs; v.vs = vs; v.exp_taddr = ta;
    return v;
  endfunction

  task automatic set_in(input logic [6:0] hb, input logic [3:0] hp,
                        input logic [4:0] vb, input logic [3:0] vp,
                        input logic ha, input logic va, input logic hs, input logic vs);
    h_block = hb; h_pixel = hp; v_block = vb; v_pixel = vp;
    h_active = ha; v_active = va; h_sync = hs; v_sync = vs;
  endtask

  // Pipeline starts empty: two reset-valued outputs precede the first real one.
  task automatic model_reset();
    exp_t r;
    r = '{act: 1'b0, hs: 1'b1, vs: 1'b1, glyph: 1'b0, hit: 1'b0};
    sbq.delete();
    sbq.push_back(r);
    sbq.push_back(r);
    m_cnt     = 5'd0;
    m_prev_vs = 1'b1;
  endtask

  task automatic push_cur();
    logic [11:0] a;
    logic [7:0]  ch, f;
    exp_t        e;
    a       = 12'(v_block) * 12'd80 + 12'(h_block);
    ch      = text_mem[a];
    f       = font_mem[{ch, v_pixel}];
    e.act   = h_active & v_active;
    e.hs    = h_sync;
    e.vs    = v_sync;
    e.glyph = (h_pixel < 4'd8) ? f[3'd7 - h_pixel[2:0]] : 1'b0;
    e.hit   = (h_block == cursor_col) && (v_block == cursor_row) &&
              (cursor_col < 7'd80) && (cursor_row < 5'd30);
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic       ep;
    logic [3:0] exp_v, act_v;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expected entry at t=%0t", $time);
    end else begin
      e  = sbq.pop_front();
      ep = e.act & (e.glyph ^ (e.hit & cursor_enable & m_cnt[4]));
      if (m_prev_vs && !e.vs) m_cnt = m_cnt + 5'd1;
      m_prev_vs = e.vs;
      exp_v = {e.hs, e.vs, e.act, ep};
      act_v = {vga_hsync, vga_vsync, vga_active, vga_pixel};
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL out {hs,vs,act,pix} t=%0t: got %b want %b (blink cnt %0d)",
                 $time, act_v, exp_v, m_cnt);
      end
    end
  endtask

  // One pixel_tick; gap = clocks between consecutive ticks.
  task automatic tick(input int gap);
    push_cur();
    pixel_tick = 1'b1;
    @(posedge clk);
    #1;
    pixel_tick = 1'b0;
    pop_check();
    for (int g = 1; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    logic [27:0] got;
    got = {text_addr, font_addr, vga_hsync, vga_vsync, vga_active, vga_pixel};
    total++;
    if (got !== {12'd0, 12'd0, 4'b1100}) begin
      bad++;
      $display("FAIL %s: got taddr=%h faddr=%h hs/vs/act/pix=%b want 000 000 1100",
               name, got[27:16], got[15:4], got[3:0]);
    end
  endtask

  task automatic run_table(input int gap);
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].hb, tbl[i].hp, tbl[i].vb, tbl[i].vp,
             tbl[i].ha, tbl[i].va, tbl[i].hs, tbl[i].vs);
      tick(gap);
      total++;
      if (text_addr !== tbl[i].exp_taddr) begin
        bad++;
        $display("FAIL text_addr[%0d] gap=%0d: got %0d want %0d", i, gap, text_addr, tbl[i].exp_taddr);
      end
      if (i > 0) begin
        total++;
        if (font_addr !== {text_mem[tbl[i-1].exp_taddr], tbl[i-1].vp}) begin
          bad++;
          $display("FAIL font_addr[%0d] gap=%0d: got %h want %h", i, gap, font_addr,
                   {text_mem[tbl[i-1].exp_taddr], tbl[i-1].vp});
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'(i * 7 + 3);
      font_mem[i] = 8'(i / 16) ^ {4'(i), 4'(i)};
    end
    text_mem[165]     = 8'h41;
    font_mem[12'h413] = 8'h80;

    //             hb    hp  vb  vp  ha va hs vs  text_addr
    tbl[0] = mk(7'd5,   0, 2,  3,  1, 1, 1, 1, 12'd165);
    tbl[1] = mk(7'd5,   1, 2,  3,  1, 1, 1, 1, 12'd165);
    tbl[2] = mk(7'd5,   8, 2,  3,  1, 1, 1, 1, 12'd165);
    tbl[3] = mk(7'd5,   9, 2,  3,  1, 1, 1, 1, 12'd165);
    tbl[4] = mk(7'd0,   0, 0,  0,  1, 1, 0, 1, 12'd0);
    tbl[5] = mk(7'd79,  7, 29, 15, 1, 1, 1, 1, 12'd2399);
    tbl[6] = mk(7'd10,  2, 1,  5,  0, 1, 1, 1, 12'd90);
    tbl[7] = mk(7'd3,   4, 4,  7,  1, 0, 1, 0, 12'd323);
    tbl[8] = mk(7'd127, 0, 31, 0,  1, 1, 1, 1, 12'd2607);
    tbl[9] = mk(7'd12,  3, 7,  9,  1, 1, 1, 1, 12'd572);

    reset_low     = 1'b0;
    pixel_tick    = 1'b0;
    cursor_enable = 1'b1;
    cursor_col    = 7'd5;
    cursor_row    = 5'd2;
    set_in(7'd0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #12;
    check_reset("reset_initial");
    reset_low = 1'b1;
    model_reset();

    // Every-clock ticks.
    run_table(1);

    // Mid-line reset: outputs must snap to reset values with no clock edge.
    set_in(7'd5, 4'd0, 5'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    reset_low = 1'b0;
    #2;
    check_reset("reset_midline");
    pixel_tick = 1'b1;
    #10;
    pixel_tick = 1'b0;
    check_reset("reset_held");
    reset_low = 1'b1;
    model_reset();

    // Same vectors with a tick every third clock; first outputs are flushed.
    run_table(3);

    // Frames: cursor cell, an out-of-range cursor cell, then a vsync pulse.
    for (int f = 0; f < 36; f++) begin
      cursor_col = 7'd5;
      cursor_row = 5'd2;
      set_in(7'd5, 4'd0, 5'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      tick((f % 2) + 1);
      cursor_col = 7'd100;
      set_in(7'd100, 4'd0, 5'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      set_in(7'd0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1);
    end
    cursor_col = 7'd5;
    set_in(7'd0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
